// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared Mini-CPU definitions used by the step sequencer and the control unit.
//   seq_state_t    : run/stop/halt state of the step sequencer
//   STEP_W_DEFAULT : default width of the micro-step counter
//   FETCH_STEPS    : first execute step (steps below this are fetch steps)
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        PAUSE  = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } seq_state_t;

    localparam int STEP_W_DEFAULT = 4;
    localparam int FETCH_STEPS    = 5;

endpackage

// File: rtl/step_sequencer_if.sv
// ----------------------------------------------------------------------------
// step_sequencer_if
// Bundles the control-unit handshake and status signals of the step sequencer.
//   master : the control/debug side; drives start, stop, SC_inc, SC_reset,
//            HALT (and ss_mode/ss_go), observes step, cpu_run, halted, fault,
//            retire_cnt, cycle_cnt
//   slave  : the step sequencer itself (opposite directions)
// Optional single-step signals exist only when STEP_SEQ_SINGLE_STEP_EN is
// defined.
// ----------------------------------------------------------------------------
interface step_sequencer_if
    import cpu_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT,
    parameter int CNT_W  = 16
);

    logic              start;
    logic              stop;
    logic              SC_inc;
    logic              SC_reset;
    logic              HALT;
    logic [STEP_W-1:0] step;
    logic              cpu_run;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  retire_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
`ifdef STEP_SEQ_SINGLE_STEP_EN
    logic              ss_mode;
    logic              ss_go;

    modport master (
        output start, stop, SC_inc, SC_reset, HALT, ss_mode, ss_go,
        input  step, cpu_run, halted, fault, retire_cnt, cycle_cnt
    );

    modport slave (
        input  start, stop, SC_inc, SC_reset, HALT, ss_mode, ss_go,
        output step, cpu_run, halted, fault, retire_cnt, cycle_cnt
    );
`else
    modport master (
        output start, stop, SC_inc, SC_reset, HALT,
        input  step, cpu_run, halted, fault, retire_cnt, cycle_cnt
    );

    modport slave (
        input  start, stop, SC_inc, SC_reset, HALT,
        output step, cpu_run, halted, fault, retire_cnt, cycle_cnt
    );
`endif

endinterface

// File: rtl/wrap_counter.sv
// ----------------------------------------------------------------------------
// wrap_counter
// Free-running up counter that wraps modulo 2^WIDTH.
//   clk   : clock (rising edge)
//   clr_n : asynchronous active-low clear
//   en    : count enable, one increment per enabled clock
//   count : current count
// ----------------------------------------------------------------------------
module wrap_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// ----------------------------------------------------------------------------
// step_sequencer
// Owns the micro-step counter decoded by the control unit and the
// IDLE/RUN/PAUSE/HALTED/FAULT state that drives cpu_run. Also keeps a
// retired-instruction counter and a run-cycle counter for debug.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : step_sequencer_if.slave (start, stop, SC_inc, SC_reset, HALT in;
//           step, cpu_run, halted, fault, retire_cnt, cycle_cnt out)
// Optional feature macro: STEP_SEQ_SINGLE_STEP_EN adds ss_mode/ss_go and the
// PAUSE behaviour; without it the sequencer acts as if ss_mode were 0.
// ----------------------------------------------------------------------------
module step_sequencer
    import cpu_pkg::*;
#(
    parameter int STEP_W   = STEP_W_DEFAULT,
    parameter int MAX_STEP = 15,
    parameter int CNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    step_sequencer_if.slave bus
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [STEP_W-1:0] step_nxt;
    logic              stop_pend;
    logic              stop_pend_nxt;
    logic              ss_mode_i;
    logic              ss_go_i;
    logic              retire;
    logic              in_run;

`ifdef STEP_SEQ_SINGLE_STEP_EN
    assign ss_mode_i = bus.ss_mode;
    assign ss_go_i   = bus.ss_go;
`else
    assign ss_mode_i = 1'b0;
    assign ss_go_i   = 1'b0;
`endif

    assign in_run = (state == RUN);

    // A HALT in the same cycle wins over the end of the instruction, so no
    // retire is counted then.
    assign retire = in_run && bus.SC_reset && (bus.step != '0) && !bus.HALT;

    // A stop arriving together with the retire must take effect on it, so
    // the pending flag is looked at together with the live stop input.
    always_comb begin
        state_nxt     = state;
        step_nxt      = bus.step;
        stop_pend_nxt = stop_pend;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                end
            end
            RUN: begin
                stop_pend_nxt = stop_pend | bus.stop;
                if (bus.HALT) begin
                    state_nxt = HALTED;
                end else if (bus.SC_inc && !bus.SC_reset &&
                             (bus.step == STEP_W'(MAX_STEP))) begin
                    state_nxt = FAULT;
                end else begin
                    if (bus.SC_reset) begin
                        step_nxt = '0;
                    end else if (bus.SC_inc) begin
                        step_nxt = bus.step + 1'b1;
                    end
                    if (retire) begin
                        if (stop_pend_nxt) begin
                            state_nxt = IDLE;
                        end else if (ss_mode_i) begin
                            state_nxt = PAUSE;
                        end
                    end
                end
                if (state_nxt != RUN) begin
                    stop_pend_nxt = 1'b0;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (ss_go_i) begin
                    state_nxt = RUN;
                end
            end
            HALTED: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (bus.start) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            stop_pend   <= 1'b0;
            bus.step    <= '0;
            bus.cpu_run <= 1'b0;
            bus.halted  <= 1'b0;
            bus.fault   <= 1'b0;
        end else begin
            state       <= state_nxt;
            stop_pend   <= stop_pend_nxt;
            bus.step    <= step_nxt;
            bus.cpu_run <= (state_nxt == RUN);
            bus.halted  <= (state_nxt == HALTED);
            bus.fault   <= (state_nxt == FAULT);
        end
    end

    wrap_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (retire),
        .count (bus.retire_cnt)
    );

    wrap_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (in_run),
        .count (bus.cycle_cnt)
    );

endmodule

// File: tb/tb_step_sequencer.sv
// ----------------------------------------------------------------------------
// tb_step_sequencer
// Directed testbench for step_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, away from the edge.
// Single-step checks are compiled in when STEP_SEQ_SINGLE_STEP_EN is defined.
// ----------------------------------------------------------------------------
module tb_step_sequencer;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    step_sequencer_if #(.STEP_W(4), .CNT_W(16)) bus ();

    step_sequencer #(
        .STEP_W   (4),
        .MAX_STEP (15),
        .CNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int unsigned actual,
                               input int unsigned expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of control-unit inputs, then move to the sample point
    // just after the next rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic inc,
                                 input logic clr, input logic h);
        bus.start    = s;
        bus.stop     = p;
        bus.SC_inc   = inc;
        bus.SC_reset = clr;
        bus.HALT     = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.SC_inc   = 1'b0;
        bus.SC_reset = 1'b0;
        bus.HALT     = 1'b0;
`ifdef STEP_SEQ_SINGLE_STEP_EN
        bus.ss_mode  = 1'b0;
        bus.ss_go    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_step", bus.step, 0);
        checkOutput("rst_cpu_run", bus.cpu_run, 0);
        checkOutput("rst_halted", bus.halted, 0);
        checkOutput("rst_fault", bus.fault, 0);
        checkOutput("rst_retire", bus.retire_cnt, 0);
        checkOutput("rst_cycle", bus.cycle_cnt, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] start, 7 increments, end of instruction");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_run", bus.cpu_run, 1);
        checkOutput("t1_step0", bus.step, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("t1_step_inc", bus.step, i);
        end
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t1_step_clr", bus.step, 0);
        checkOutput("t1_retire", bus.retire_cnt, 1);
        checkOutput("t1_cycle", bus.cycle_cnt, 8);
        checkOutput("t1_still_run", bus.cpu_run, 1);

        $display("[TB] HALT at step 5, restart");
        repeat (5) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t2_step5", bus.step, 5);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("t2_run", bus.cpu_run, 0);
        checkOutput("t2_halted", bus.halted, 1);
        checkOutput("t2_step_frozen", bus.step, 5);
        checkOutput("t2_no_retire", bus.retire_cnt, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_halted_hold", bus.halted, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_restart_run", bus.cpu_run, 1);
        checkOutput("t2_restart_step", bus.step, 0);
        checkOutput("t2_restart_halted", bus.halted, 0);

        $display("[TB] stop at step 3, retire at step 7");
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t3_step3", bus.step, 3);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("t3_run_after_stop", bus.cpu_run, 1);
        repeat (3) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t3_step7", bus.step, 7);
        checkOutput("t3_run_before_retire", bus.cpu_run, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_idle_run", bus.cpu_run, 0);
        checkOutput("t3_idle_step", bus.step, 0);
        checkOutput("t3_retire", bus.retire_cnt, 2);
        checkOutput("t3_halted", bus.halted, 0);

        $display("[TB] stop together with retire");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("t3b_run", bus.cpu_run, 0);
        checkOutput("t3b_retire", bus.retire_cnt, 3);

        $display("[TB] step overflow fault");
        applyStimulus(1, 0, 0, 0, 0);
        repeat (15) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t4_step15", bus.step, 15);
        checkOutput("t4_no_fault_yet", bus.fault, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t4_fault", bus.fault, 1);
        checkOutput("t4_run", bus.cpu_run, 0);
        checkOutput("t4_step_hold", bus.step, 15);
        repeat (3) applyStimulus(1, 0, 1, 0, 0);
        checkOutput("t4_fault_sticky", bus.fault, 1);
        checkOutput("t4_step_sticky", bus.step, 15);
        reset = 1'b0;
        #2;
        checkOutput("t4_rst_fault", bus.fault, 0);
        checkOutput("t4_rst_step", bus.step, 0);
        checkOutput("t4_rst_retire", bus.retire_cnt, 0);
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        $display("[TB] HALT and stop together");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("t5_halted", bus.halted, 1);
        checkOutput("t5_run", bus.cpu_run, 0);
        checkOutput("t5_step", bus.step, 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t5_idle", bus.halted, 0);
        checkOutput("t5_idle_run", bus.cpu_run, 0);

`ifdef STEP_SEQ_SINGLE_STEP_EN
        $display("[TB] single-step mode, two instructions");
        bus.ss_mode = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_pause1_run", bus.cpu_run, 0);
        checkOutput("t6_retire1", bus.retire_cnt, 1);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t6_pause1_hold", bus.cpu_run, 0);
        checkOutput("t6_pause1_step", bus.step, 0);
        bus.ss_go = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        bus.ss_go = 1'b0;
        checkOutput("t6_go1", bus.cpu_run, 1);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_pause2_run", bus.cpu_run, 0);
        checkOutput("t6_retire2", bus.retire_cnt, 2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_pause2_hold", bus.cpu_run, 0);
        bus.ss_go = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        bus.ss_go = 1'b0;
        checkOutput("t6_go2", bus.cpu_run, 1);
        bus.ss_mode = 1'b0;
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t6_stop_idle", bus.cpu_run, 0);
`endif

        $display("[TB] asynchronous reset at step 6");
        applyStimulus(1, 0, 0, 0, 0);
        repeat (6) applyStimulus(0, 0, 1, 0, 0);
        checkOutput("t7_step6", bus.step, 6);
        checkOutput("t7_run", bus.cpu_run, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t7_rst_step", bus.step, 0);
        checkOutput("t7_rst_run", bus.cpu_run, 0);
        checkOutput("t7_rst_halted", bus.halted, 0);
        checkOutput("t7_rst_fault", bus.fault, 0);
        checkOutput("t7_rst_retire", bus.retire_cnt, 0);
        checkOutput("t7_rst_cycle", bus.cycle_cnt, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("t7_held_step", bus.step, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
